// File: rtl/padcfg_reg_responder.sv
// Register-bus target holding per-pad mux-select/config registers plus a sticky lock.
// Optional PADCFG_ERR_CNT_EN adds a saturating error counter at 8*NumPads+4 (err_cnt_o).

module padcfg_pad_slot #(
    parameter int SelW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mux_we,
    input  logic            cfg_we,
    input  logic [7:0]      wdata,
    output logic [SelW-1:0] mux_q,
    output logic [2:0]      cfg_q
);
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mux_q <= '0;
            cfg_q <= '0;
        end else begin
            if (mux_we) mux_q <= wdata[SelW-1:0];
            if (cfg_we) cfg_q <= wdata[2:0];
        end
    end
endmodule

module padcfg_reg_responder #(
    parameter int NumPads      = 4,
    parameter int SelW         = 2,
    parameter int MaxSel       = 2,
    parameter int ReadyLatency = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    input  logic                     req_write_i,
    input  logic [31:0]              req_addr_i,
    input  logic [31:0]              req_wdata_i,
    input  logic [3:0]               req_wstrb_i,
    output logic                     rsp_ready_o,
    output logic [31:0]              rsp_rdata_o,
    output logic                     rsp_error_o,
    output logic [NumPads*SelW-1:0]  mux_sel_o,
    output logic [NumPads*3-1:0]     cfg_o,
    output logic                     locked_o
`ifdef PADCFG_ERR_CNT_EN
    ,
    output logic [15:0]              err_cnt_o
`endif
);
    localparam int          PIW       = (NumPads > 1) ? $clog2(NumPads) : 1;
    localparam logic [31:0] LOCK_ADDR = 32'(8 * NumPads);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state_q, state_d;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        locked_q;

    logic [NumPads-1:0][SelW-1:0] mux_q;
    logic [NumPads-1:0][2:0]      cfg_q;

    // In IDLE the live bus is decoded so a zero-latency response can be registered
    // on the accept edge; afterwards the captured request is used.
    logic        cur_write;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    logic        is_pad, is_lock, is_cnt, in_range;
    logic [PIW-1:0] pad_idx;
    logic        err_val;
    logic [31:0] rd_val;
    logic        wr_en;

`ifdef PADCFG_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

    always_comb begin
        cur_write = (state_q == IDLE) ? req_write_i : write_q;
        cur_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
        cur_wstrb = (state_q == IDLE) ? req_wstrb_i : wstrb_q;
        is_pad    = cur_addr < LOCK_ADDR;
        is_lock   = cur_addr == LOCK_ADDR;
`ifdef PADCFG_ERR_CNT_EN
        is_cnt    = cur_addr == LOCK_ADDR + 32'd4;
`else
        is_cnt    = 1'b0;
`endif
        in_range  = is_pad || is_lock || is_cnt;
        pad_idx   = cur_addr[PIW+2:3];
    end

    always_comb begin
        err_val = 1'b0;
        rd_val  = '0;
        if (cur_addr[1:0] != 2'b00 || !in_range) begin
            err_val = 1'b1;
        end else if (is_pad) begin
            if (cur_write && locked_q)
                err_val = 1'b1;
            else if (cur_write && !cur_addr[2] && cur_wstrb[0] &&
                     32'(cur_wdata[SelW-1:0]) > 32'(MaxSel))
                err_val = 1'b1;
            else if (!cur_write)
                rd_val = cur_addr[2] ? 32'(cfg_q[pad_idx]) : 32'(mux_q[pad_idx]);
        end else if (is_lock) begin
            if (!cur_write) rd_val = 32'(locked_q);
        end
`ifdef PADCFG_ERR_CNT_EN
        else if (is_cnt) begin
            if (!cur_write) rd_val = 32'(err_cnt_q);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid_i) state_d = (ReadyLatency == 0) ? RESP : WAIT;
            WAIT: if (cnt_q == 4'd1) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes commit on the edge that leaves RESP, gated by the registered error.
    assign wr_en = (state_q == RESP) && write_q && !rsp_error_o && wstrb_q[0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_ready_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
                cnt_q   <= 4'(ReadyLatency);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            rsp_ready_o <= (state_d == RESP);
            rsp_rdata_o <= (state_d == RESP && !err_val && !cur_write) ? rd_val : '0;
            rsp_error_o <= (state_d == RESP) && err_val;
            if (wr_en && is_lock && wdata_q[0]) locked_q <= 1'b1;
        end
    end

`ifdef PADCFG_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            err_cnt_q <= '0;
        else if (state_q == RESP && rsp_error_o && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
        else if (wr_en && is_cnt)
            err_cnt_q <= '0;
    end
`endif

    for (genvar i = 0; i < NumPads; i++) begin : g_pad
        padcfg_pad_slot #(.SelW(SelW)) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .mux_we (wr_en && is_pad && !addr_q[2] && pad_idx == PIW'(i)),
            .cfg_we (wr_en && is_pad &&  addr_q[2] && pad_idx == PIW'(i)),
            .wdata  (wdata_q[7:0]),
            .mux_q  (mux_q[i]),
            .cfg_q  (cfg_q[i])
        );
    end

    assign mux_sel_o = mux_q;
    assign cfg_o     = cfg_q;
    assign locked_o  = locked_q;
endmodule

// File: tb/tb_padcfg_reg_responder.sv
// Directed bench for padcfg_reg_responder (NumPads=4, SelW=2, MaxSel=2, ReadyLatency=1).
// Define PADCFG_ERR_CNT_EN for both bench and RTL to exercise the error counter.

module tb_padcfg_reg_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        rsp_ready_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic [7:0]  mux_sel_o;
    logic [11:0] cfg_o;
    logic        locked_o;
`ifdef PADCFG_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    padcfg_reg_responder #(.NumPads(4), .SelW(2), .MaxSel(2), .ReadyLatency(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .mux_sel_o   (mux_sel_o),
        .cfg_o       (cfg_o),
        .locked_o    (locked_o)
`ifdef PADCFG_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    // Bus driver: returns response fields and the edge count from drive to ready;
    // leaves the bench one edge past RESP so writes are visible.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = w; req_addr_i = a;
        req_wdata_i = d;    req_wstrb_i = s;
        lat = 0; rd = '0; er = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) req_valid_i = 1'b0;
        end while (!rsp_ready_o && lat < 20);
        if (!rsp_ready_o) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout addr=%h: no ready within %0d cycles", a, lat);
        end
        rd = rsp_rdata_o; er = rsp_error_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({rsp_ready_o, rsp_rdata_o, rsp_error_o, mux_sel_o, cfg_o, locked_o} !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b rd=%h er=%b mux=%h cfg=%h lk=%b want all 0",
                     rsp_ready_o, rsp_rdata_o, rsp_error_o, mux_sel_o, cfg_o, locked_o);
        end
    endtask

    task automatic test_mux_write_read();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h00, 32'h2, 4'hF, rd, er, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", lat); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL wr_mux_rsp got er=%b rd=%h want 0/0", er, rd); end
        n_cmp++; if (mux_sel_o[1:0] !== 2'd2) begin n_fail++; $display("FAIL mux0_value got %0d want 2", mux_sel_o[1:0]); end
        n_cmp++; if (rsp_ready_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL ready_pulse got rdy=%b rd=%h want 0/0", rsp_ready_o, rsp_rdata_o); end
        access(1'b0, 32'h00, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h2 || er !== 1'b0) begin n_fail++; $display("FAIL rd_mux0 got rd=%h er=%b want 2/0", rd, er); end
    endtask

    task automatic test_cfg_strobe();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h14, 32'h7, 4'hF, rd, er, lat);
        n_cmp++; if (cfg_o[8:6] !== 3'b111) begin n_fail++; $display("FAIL cfg2_write got %b want 111", cfg_o[8:6]); end
        n_cmp++; if (cfg_o[5:0] !== 6'd0 || cfg_o[11:9] !== 3'd0) begin n_fail++; $display("FAIL cfg_others got %h want 0 outside pad2", cfg_o); end
        access(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL rd_cfg2 got %h want 7", rd); end
        access(1'b1, 32'h14, 32'h5, 4'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b0 || cfg_o[8:6] !== 3'b111) begin n_fail++; $display("FAIL strb0_noop got er=%b cfg=%b want 0/111", er, cfg_o[8:6]); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h08, 32'h3, 4'hF, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || mux_sel_o[3:2] !== 2'd0) begin n_fail++; $display("FAIL maxsel_reject got er=%b mux1=%0d want 1/0", er, mux_sel_o[3:2]); end
        access(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misaligned got er=%b rd=%h want 1/0", er, rd); end
        access(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL out_of_range got er=%b want 1", er); end
`ifndef PADCFG_ERR_CNT_EN
        access(1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL cnt_addr_absent got er=%b want 1", er); end
`else
        access(1'b0, 32'h28, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL beyond_cnt got er=%b want 1", er); end
`endif
    endtask

    task automatic test_lock();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h20, 32'h1, 4'hF, rd, er, lat);
        n_cmp++; if (locked_o !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL lock_set got lk=%b er=%b want 1/0", locked_o, er); end
        access(1'b1, 32'h00, 32'h1, 4'hF, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || mux_sel_o[1:0] !== 2'd2) begin n_fail++; $display("FAIL locked_write got er=%b mux0=%0d want 1/2", er, mux_sel_o[1:0]); end
        access(1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat);
        n_cmp++; if (locked_o !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL lock_sticky got lk=%b er=%b want 1/0", locked_o, er); end
        access(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL lock_read got %h want 1", rd); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; logic er; int lat; logic seen;
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h18;
        req_wdata_i = 32'h1; req_wstrb_i = 4'hF;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_ready_o) seen = 1'b1;
        end
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        if (rsp_ready_o) seen = 1'b1;
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_ready got ready pulse want none"); end
        n_cmp++;
        if ({rsp_rdata_o, rsp_error_o, mux_sel_o, cfg_o, locked_o} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_clear got rd=%h er=%b mux=%h cfg=%h lk=%b want all 0",
                     rsp_rdata_o, rsp_error_o, mux_sel_o, cfg_o, locked_o);
        end
        access(1'b0, 32'h18, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL rd_after_reset got rd=%h er=%b want 0/0", rd, er); end
    endtask

    task automatic test_err_cnt();
`ifdef PADCFG_ERR_CNT_EN
        logic [31:0] rd; logic er; int lat;
        access(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
        access(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        access(1'b1, 32'h08, 32'h3, 4'hF, rd, er, lat);
        access(1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h3 || er !== 1'b0) begin n_fail++; $display("FAIL errcnt_read got rd=%h er=%b want 3/0", rd, er); end
        n_cmp++; if (err_cnt_o !== 16'd3) begin n_fail++; $display("FAIL errcnt_port got %0d want 3", err_cnt_o); end
        access(1'b1, 32'h24, 32'h0, 4'h1, rd, er, lat);
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL errcnt_clear got %0d want 0", err_cnt_o); end
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b0;
        test_mux_write_read();
        test_cfg_strobe();
        test_errors();
        test_lock();
        test_reset_midflight();
        test_err_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
